lifo_stack_p: RTL and testbench
===============================

LIFO_STACK_P -- requirements
Module: lifo_stack_p

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 128, maximum number of stored words (>=2).
REQ-003 SHALL have local parameter CW = clog2(DEPTH+1), the width of the occupancy count.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port clr, input, 1, synchronous clear of contents and flags.
REQ-007 SHALL have port push, input, 1, write din onto stack this cycle.
REQ-008 SHALL have port pop, input, 1, remove top word this cycle.
REQ-009 SHALL have port din, input, WIDTH, push data.
REQ-010 SHALL have port dout, output, WIDTH, registered current top-of-stack word.
REQ-011 SHALL have port count, output, CW, registered number of stored words.
REQ-012 SHALL have outputs empty and full, 1 bit each, with empty = (count==0) and full = (count==DEPTH).
REQ-013 SHALL have outputs overflow and underflow, 1 bit each, sticky error flags.
REQ-014 SHALL have output parity, 1 bit, XOR of every bit of every stored word.

Function
REQ-015 SHALL hold the top word in a dedicated register (dout) and words below it in a DEPTH-1 entry array, so dout is valid in the cycle after the operating edge with no read latency.
REQ-016 SHALL give clr priority over push/pop: count<=0, dout<=0, parity<=0, overflow<=0, underflow<=0; array contents are don't-care.
REQ-017 Push only, not full: SHALL move the old dout into array[count-1] when count>0, set dout<=din, count<=count+1, and parity<=parity^(XOR-reduce din).
REQ-018 Push only, full: SHALL leave contents, count, dout and parity unchanged and set overflow<=1.
REQ-019 Pop only, not empty: SHALL set dout<=array[count-2] (dout<=0 when count==1), count<=count-1, and parity<=parity^(XOR-reduce old dout).
REQ-020 Pop only, empty: SHALL leave all state unchanged and set underflow<=1.
REQ-021 Push and pop, count>0 (including full): SHALL replace the top in one cycle: dout<=din, count unchanged, parity<=parity^XOR(old dout)^XOR(din), no flag set.
REQ-022 Push and pop, empty: SHALL behave as push only (REQ-017) and set no flag.
REQ-023 SHALL keep count within 0..DEPTH; no pointer wrap-around is permitted under any input sequence.
REQ-024 SHALL drive dout to 0 whenever count==0.
REQ-025 SHALL clear overflow and underflow only via clr or rst_n; subsequent legal operations SHALL NOT clear them.
REQ-026 SHALL have no idle states: a new operation may be issued every cycle, back-to-back, at full throughput.

Reset
REQ-027 On rst_n low, SHALL asynchronously set count=0, dout=0, parity=0, overflow=0 and underflow=0, giving empty=1 and full=0.
REQ-028 SHALL NOT reset array storage; its contents are unobservable until rewritten.
REQ-029 Reset asserted mid-sequence SHALL abandon any in-flight operation; the first operation after rst_n deassertion SHALL act on an empty stack.

Verification
REQ-030 WIDTH=8, DEPTH=4: push A5,3C,0F in consecutive cycles -> count=3, dout=0F, parity=0; three pops -> dout 3C, A5, 00, empty=1.
REQ-031 DEPTH=4: five pushes 01..05 -> full=1 after fourth, overflow=1, dout=04, count=4; pop -> dout=03.
REQ-032 Pop on empty -> underflow=1, count=0, dout=00; push 81 -> underflow still 1, dout=81; clr -> all flags 0.
REQ-033 Push+pop with count=4 (full), din=FF over top 04 -> count=4, dout=FF, no overflow; pop -> dout=03.
REQ-034 Push+pop on empty with din=07 -> count=1, dout=07, parity=1, underflow=0.
REQ-035 Assert rst_n low between clock edges with count=2 -> outputs zero immediately, before the next edge; after release, pop -> underflow=1.

Source files
------------

// File: rtl/lifo_stack_p.sv
// LIFO stack with the top word held in a dedicated output register and the
// remaining words in a DEPTH-1 entry array; tracks occupancy, parity and sticky errors.
module lifo_stack_p #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 128,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow,
   output logic             parity
);

   localparam int unsigned AW = (DEPTH - 1 > 1) ? $clog2(DEPTH - 1) : 1;

   logic [WIDTH-1:0] mem [DEPTH-1];

   logic [WIDTH-1:0] dout_q, dout_d;
   logic [CW-1:0]    count_q, count_d;
   logic             parity_q, parity_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             mem_we;
   logic [AW-1:0]    wr_idx, rd_idx;
   logic             is_empty, is_full;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CW'(DEPTH));

   // The old top lands just below the new top; the word under the top sits at count-2.
   assign wr_idx = AW'(count_q - CW'(1));
   assign rd_idx = AW'(count_q - CW'(2));

   always_comb begin
      dout_d   = dout_q;
      count_d  = count_q;
      parity_d = parity_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      mem_we   = 1'b0;
      if (clr) begin
         dout_d   = '0;
         count_d  = '0;
         parity_d = 1'b0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (is_full) begin
                  ovf_d = 1'b1;
               end else begin
                  mem_we   = !is_empty;
                  dout_d   = din;
                  count_d  = count_q + CW'(1);
                  parity_d = parity_q ^ (^din);
               end
            end
            2'b01: begin
               if (is_empty) begin
                  udf_d = 1'b1;
               end else begin
                  dout_d   = (count_q == CW'(1)) ? '0 : mem[rd_idx];
                  count_d  = count_q - CW'(1);
                  parity_d = parity_q ^ (^dout_q);
               end
            end
            2'b11: begin
               // Replace the top in place; on an empty stack this degenerates to a push.
               dout_d = din;
               if (is_empty) begin
                  count_d  = CW'(1);
                  parity_d = parity_q ^ (^din);
               end else begin
                  parity_d = parity_q ^ (^dout_q) ^ (^din);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q   <= '0;
         count_q  <= '0;
         parity_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         dout_q   <= dout_d;
         count_q  <= count_d;
         parity_q <= parity_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_idx] <= dout_q;
      end
   end

   assign dout      = dout_q;
   assign count     = count_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = ovf_q;
   assign underflow = udf_q;
   assign parity    = parity_q;

endmodule

// File: tb/tb_lifo_stack_p.sv
// Self-checking bench for lifo_stack_p: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_lifo_stack_p;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr, push, pop;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic [CW-1:0]    count;
   logic             empty, full, overflow, underflow, parity;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   // Reference model: queue with the top at the back.
   logic [WIDTH-1:0] q [$];
   logic             m_ovf, m_udf;

   lifo_stack_p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .push      (push),
      .pop       (pop),
      .din       (din),
      .dout      (dout),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow),
      .parity    (parity)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic m_parity();
      logic p = 1'b0;
      foreach (q[i]) p ^= ^q[i];
      return p;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
   endtask

   task automatic model_step(input logic p, input logic o, input logic c, input logic [WIDTH-1:0] d);
      if (c) begin
         model_reset();
      end else if (p && o) begin
         if (q.size() > 0) q[q.size()-1] = d;
         else q.push_back(d);
      end else if (p) begin
         if (q.size() == DEPTH) m_ovf = 1'b1;
         else q.push_back(d);
      end else if (o) begin
         if (q.size() == 0) m_udf = 1'b1;
         else void'(q.pop_back());
      end
   endtask

   task automatic check_all(input string tag);
      logic [WIDTH-1:0] top;
      top = (q.size() > 0) ? q[q.size()-1] : '0;
      check({tag, ".count"}, 32'(count), 32'(q.size()));
      check({tag, ".dout"}, 32'(dout), 32'(top));
      check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
      check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
      check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".udf"}, 32'(underflow), 32'(m_udf));
      check({tag, ".parity"}, 32'(parity), 32'(m_parity()));
   endtask

   // Drive one operation for a single edge, then compare against the model.
   task automatic do_op(input string tag, input logic p, input logic o, input logic c,
                        input logic [WIDTH-1:0] d);
      push = p; pop = o; clr = c; din = d;
      @(posedge clk);
      #1;
      model_step(p, o, c, d);
      push = 1'b0; pop = 1'b0; clr = 1'b0;
      check_all(tag);
   endtask

   task automatic hard_reset();
      rst_n = 1'b0;
      #3;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Three pushes then three pops.
      do_op("p_a5", 1, 0, 0, 8'hA5);
      do_op("p_3c", 1, 0, 0, 8'h3C);
      do_op("p_0f", 1, 0, 0, 8'h0F);
      check("r030_dout", 32'(dout), 32'h0F);
      check("r030_parity", 32'(parity), 32'h0);
      do_op("pop1", 0, 1, 0, 8'h00);
      check("r030_pop1", 32'(dout), 32'h3C);
      do_op("pop2", 0, 1, 0, 8'h00);
      check("r030_pop2", 32'(dout), 32'hA5);
      do_op("pop3", 0, 1, 0, 8'h00);
      check("r030_pop3", 32'(dout), 32'h00);

      // Fill past full, then replace the top while full.
      do_op("clr0", 0, 0, 1, 8'h00);
      for (int i = 1; i <= 5; i++) do_op("fill", 1, 0, 0, 8'(i));
      check("r031_ovf", 32'(overflow), 32'h1);
      check("r031_dout", 32'(dout), 32'h04);
      do_op("swap_full", 1, 1, 0, 8'hFF);
      check("r033_dout", 32'(dout), 32'hFF);
      check("r033_count", 32'(count), 32'd4);
      do_op("pop_after_swap", 0, 1, 0, 8'h00);
      check("r033_pop", 32'(dout), 32'h03);

      // Underflow is sticky across legal operations until clr.
      do_op("clr1", 0, 0, 1, 8'h00);
      do_op("pop_empty", 0, 1, 0, 8'h00);
      do_op("push_81", 1, 0, 0, 8'h81);
      check("r032_udf_sticky", 32'(underflow), 32'h1);
      do_op("clr2", 1, 1, 1, 8'h55);
      check("r032_clr_udf", 32'(underflow), 32'h0);

      // Push and pop on an empty stack behaves as a push.
      do_op("swap_empty", 1, 1, 0, 8'h07);
      check("r034_parity", 32'(parity), 32'h1);

      // Asynchronous reset between edges with two words stored.
      do_op("p_x", 1, 0, 0, 8'h11);
      check("r035_pre", 32'(count), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #1;
      rst_n = 1'b1;
      do_op("pop_after_rst", 0, 1, 0, 8'h00);
      check("r035_udf", 32'(underflow), 32'h1);

      // Random traffic, with occasional clr and reset.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            hard_reset();
            check_all("rnd_rst");
         end else begin
            do_op("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 39) == 0), 8'($urandom));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
